// File: rtl/gmul_seq.sv
// rtl/gmul_seq.sv - iterative GF(2^DWIDTH) multiplier, one multiplier byte per cycle
//
// gmul_primitive: combinational p = a * b mod (x^DWIDTH + m), with b one byte wide
//   a  in  DWIDTH  multiplicand
//   b  in  8       multiplier byte
//   m  in  DWIDTH  reduction polynomial without the x^DWIDTH term
//   p  out DWIDTH  reduced product
//
// gmul_seq: p = a * b mod (x^DWIDTH + m), b consumed MSB byte first (Horner form)
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   in_valid   in   1       operand set valid
//   in_ready   out  1       block can accept an operand set
//   in_a       in   DWIDTH  multiplicand
//   in_b       in   DWIDTH  multiplier
//   in_m       in   DWIDTH  reduction polynomial without the x^DWIDTH term
//   out_valid  out  1       product valid
//   out_ready  in   1       consumer accepts product
//   out_p      out  DWIDTH  product

module gmul_primitive #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [7:0]        b,
  input  logic [DWIDTH-1:0] m,
  output logic [DWIDTH-1:0] p
);

  // Bitwise Horner over the multiplier byte: shift-reduce, then add a where b has a one.
  always_comb begin
    logic [DWIDTH-1:0] acc;
    acc = '0;
    for (int i = 7; i >= 0; i--) begin
      acc = {acc[DWIDTH-2:0], 1'b0} ^ (m & {DWIDTH{acc[DWIDTH-1]}});
      if (b[i]) begin
        acc = acc ^ a;
      end
    end
    p = acc;
  end

endmodule

module gmul_seq #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic [DWIDTH-1:0] in_m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_p
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] a_q;
  logic [DWIDTH-1:0] b_q;
  logic [DWIDTH-1:0] m_q;
  logic [DWIDTH-1:0] acc;
  logic [CW-1:0]     cnt;

  logic [7:0]        b_byte;
  logic [DWIDTH-1:0] part;
  logic [DWIDTH-1:0] acc_next;

  // Multiply by x^8 and reduce: eight single-bit shift-reduce steps.
  function automatic logic [DWIDTH-1:0] xt8(input logic [DWIDTH-1:0] v,
                                            input logic [DWIDTH-1:0] poly);
    logic [DWIDTH-1:0] r;
    r = v;
    for (int i = 0; i < 8; i++) begin
      r = {r[DWIDTH-2:0], 1'b0} ^ (poly & {DWIDTH{r[DWIDTH-1]}});
    end
    return r;
  endfunction

  assign b_byte = b_q[8*cnt +: 8];

  gmul_primitive #(
    .DWIDTH(DWIDTH)
  ) u_prim (
    .a (a_q),
    .b (b_byte),
    .m (m_q),
    .p (part)
  );

  assign acc_next = xt8(acc, m_q) ^ part;

  // Ready comes from state alone so it can never combinationally loop with in_valid.
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_p     <= '0;
      acc       <= '0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            acc   <= '0;
            cnt   <= CW'(NBYTES - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          if (cnt == '0) begin
            out_p     <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // out_p is left holding the product after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmul_seq.sv
// tb/tb_gmul_seq.sv - self-checking bench for gmul_seq at DWIDTH=32 and DWIDTH=8

module tb_gmul_seq;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, in_m, out_p;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_a8, in_b8, in_m8, out_p8;

  int checks;
  int failures;

  gmul_seq #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_m      (in_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  gmul_seq #(.DWIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .in_b      (in_b8),
    .in_m      (in_m8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_p     (out_p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m;
    logic [31:0] p;
  } vec_t;

  // Reference: full carry-less product, then polynomial long division by x^w + m.
  function automatic logic [31:0] gf_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] m, input int w);
    logic [63:0] prod;
    logic [63:0] poly;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    prod = 64'd0;
    for (int i = 0; i < w; i++) begin
      if (b[i]) prod = prod ^ (({32'd0, a} & mask) << i);
    end
    poly = ({32'd0, m} & mask) | (64'd1 << w);
    for (int j = 2*w - 2; j >= w; j--) begin
      if (prod[j]) prod = prod ^ (poly << (j - w));
    end
    return 32'(prod & mask);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_m = m;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the block must work from its latched copies.
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_m = $urandom;
  endtask

  task automatic wait32(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish32();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                     input logic [7:0] exp, input string nm);
    int lat;
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!in_ready8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    in_valid8 = 1'b1;
    in_a8 = a;
    in_b8 = b;
    in_m8 = m;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    in_a8 = 8'($urandom);
    in_b8 = 8'($urandom);
    in_m8 = 8'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid8 && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd1);
    chk(nm, 64'(out_p8), 64'(exp));
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
  endtask

  vec_t v32[7];
  vec_t v8[6];

  initial begin
    int lat;
    int cyc;
    bit hs;
    logic [31:0] a, b, m, exp;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;  out_ready  = 1'b0;
    in_a = '0;  in_b = '0;  in_m = '0;
    in_valid8 = 1'b0;  out_ready8 = 1'b0;
    in_a8 = '0; in_b8 = '0; in_m8 = '0;

    v32[0] = '{32'h00000001, 32'hDEADBEEF, 32'h000000C5, 32'hDEADBEEF};
    v32[1] = '{32'h80000000, 32'h00000002, 32'h000000C5, 32'h000000C5};
    v32[2] = '{32'h12345678, 32'h00000001, 32'h87654321, 32'h12345678};
    v32[3] = '{32'h00000000, 32'hFFFFFFFF, 32'h000000C5, 32'h00000000};
    v32[4] = '{32'hCAFEBABE, 32'h00000000, 32'h000000C5, 32'h00000000};
    v32[5] = '{32'h00000002, 32'h80000000, 32'h0000008D, 32'h0000008D};
    v32[6] = '{32'h00000100, 32'h01000000, 32'h000000C5, 32'h000000C5};

    v8[0] = '{32'h57, 32'h83, 32'h1B, 32'hC1};
    v8[1] = '{32'h57, 32'h13, 32'h1B, 32'hFE};
    v8[2] = '{32'h57, 32'h02, 32'h1B, 32'hAE};
    v8[3] = '{32'h53, 32'hCA, 32'h1B, 32'h01};
    v8[4] = '{32'h00, 32'hFF, 32'h1B, 32'h00};
    v8[5] = '{32'h80, 32'h02, 32'h1B, 32'h1B};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_in_ready8", 64'(in_ready8), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // 8-bit AES field vectors plus a few random ones
    for (int i = 0; i < 6; i++) begin
      op8(8'(v8[i].a), 8'(v8[i].b), 8'(v8[i].m), 8'(v8[i].p), $sformatf("vec8[%0d]", i));
    end
    for (int i = 0; i < 20; i++) begin
      a = 32'($urandom_range(0, 255));
      b = 32'($urandom_range(0, 255));
      op8(8'(a), 8'(b), 8'h1B, 8'(gf_ref(a, b, 32'h1B, 8)), "rand8");
    end

    // 32-bit directed vectors with latency
    for (int i = 0; i < 7; i++) begin
      start32(v32[i].a, v32[i].b, v32[i].m);
      wait32(lat);
      chk($sformatf("vec32[%0d]_lat", i), 64'(lat), 64'd4);
      chk($sformatf("vec32[%0d]", i), 64'(out_p), 64'(v32[i].p));
      finish32();
    end

    // Backpressure in DONE with ignored in_valid pulses
    a = 32'h12345678; b = 32'h9ABCDEF0; m = 32'h000000C5;
    exp = gf_ref(a, b, m, 32);
    start32(a, b, m);
    wait32(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_a = $urandom;
      in_b = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_p", 64'(out_p), 64'(exp));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    finish32();
    @(negedge clk);
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_out_p_hold", 64'(out_p), 64'(exp));

    // Reset during the second BUSY cycle discards the operation
    start32(32'h11111111, 32'h22222222, 32'h000000C5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_p", 64'(out_p), 64'd0);
    chk("midrst_in_ready1", 64'(in_ready), 64'd1);
    hs = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) hs = 1'b1;
    end
    chk("midrst_no_output", 64'(hs), 64'd0);
    start32(32'h00000000, 32'h12345678, 32'h000000C5);
    wait32(lat);
    chk("midrst_new_lat", 64'(lat), 64'd4);
    chk("midrst_new_p", 64'(out_p), 64'd0);
    finish32();

    // Random back-to-back operations with random out_ready
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      m = $urandom;
      if (i % 97 == 0) a = '0;
      if (i % 89 == 0) b = '0;
      exp = gf_ref(a, b, m, 32);
      start32(a, b, m);
      hs = 1'b0;
      cyc = 0;
      while (!hs && cyc < 200) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          chk("rand32", 64'(out_p), 64'(exp));
          hs = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      out_ready = 1'b0;
      if (!hs) chk("rand32_timeout", 64'd0, 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
